// File: rtl/order_ingress_sched_pkg.sv
// Shared types and field layout for the order ingress scheduler.
// An order word is {Price[31:16], ID[15], Qty[14:0]}; a FIFO entry prepends the is_buy bit.
package order_ingress_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    localparam logic SRC_NET = 1'b0;
    localparam logic SRC_BOT = 1'b1;

    localparam int ORDER_W = 32;
    localparam int ENTRY_W = ORDER_W + 1;
    localparam int ID_BIT  = 15;
    localparam int QTY_MSB = 14;

    // The ID bit carries the source (IS_BOT), whatever the requester sent.
    function automatic logic [ENTRY_W-1:0] stamp_entry(input logic is_buy,
                                                       input logic [ORDER_W-1:0] data,
                                                       input logic src);
        logic [ORDER_W-1:0] d;
        d         = data;
        d[ID_BIT] = src;
        return {is_buy, d};
    endfunction

endpackage

// File: rtl/order_ingress_sched_fifo.sv
// First-word-fall-through synchronous FIFO used once per order source.
// Pointers carry a wrap bit so full and empty are distinguishable without a count.
module ingress_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/order_ingress_sched.sv
// Merges network and strategy-bot orders into the single matching-engine port,
// one order in flight at a time, with a starvation cap protecting the bot.
module order_ingress_sched
    import order_ingress_sched_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        net_valid,
    output logic        net_ready,
    input  logic        net_is_buy,
    input  logic [31:0] net_data,
    input  logic        bot_valid,
    output logic        bot_ready,
    input  logic        bot_is_buy,
    input  logic [31:0] bot_data,
    output logic        eng_valid,
    output logic        eng_is_buy,
    output logic [31:0] eng_data,
    input  logic        eng_busy,
    output logic [15:0] issued_cnt,
    output logic [15:0] drop_cnt,
    output logic        err_no_ack,
    output logic        err_timeout,
    output logic [1:0]  dbg_state
);

    // Ingress handshake: an order transfers on a cycle where valid && ready.
    // Ready is !full, independent of a pop in the same cycle.

    localparam int          SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]  TO_LIMIT = 8'(DONE_TIMEOUT);

    state_e               state_q, state_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic [7:0]           to_cnt_q, to_cnt_d;
    logic [15:0]          issued_q, issued_d;
    logic [15:0]          drop_q, drop_d;
    logic                 err_no_ack_q, err_no_ack_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 eng_is_buy_q;
    logic [ORDER_W-1:0]   eng_data_q;

    logic                 net_full, net_empty, bot_full, bot_empty;
    logic [ENTRY_W-1:0]   net_head, bot_head, net_entry, bot_entry, sel_entry;
    logic                 net_hs, bot_hs, net_zero, bot_zero;
    logic                 net_push, bot_push, net_drop, bot_drop;
    logic                 grant_net, grant_bot;
    logic                 pop_net, pop_bot;
    logic [16:0]          drop_sum;

    assign net_ready = !net_full;
    assign bot_ready = !bot_full;

    assign net_hs   = net_valid && net_ready;
    assign bot_hs   = bot_valid && bot_ready;
    assign net_zero = (net_data[QTY_MSB:0] == '0);
    assign bot_zero = (bot_data[QTY_MSB:0] == '0);
    assign net_push = net_hs && !net_zero;
    assign bot_push = bot_hs && !bot_zero;
    assign net_drop = net_hs && net_zero;
    assign bot_drop = bot_hs && bot_zero;

    assign net_entry = stamp_entry(net_is_buy, net_data, SRC_NET);
    assign bot_entry = stamp_entry(bot_is_buy, bot_data, SRC_BOT);

    ingress_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_net_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (net_push),
        .din_i   (net_entry),
        .pop_i   (pop_net),
        .full_o  (net_full),
        .empty_o (net_empty),
        .head_o  (net_head)
    );

    ingress_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_bot_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bot_push),
        .din_i   (bot_entry),
        .pop_i   (pop_bot),
        .full_o  (bot_full),
        .empty_o (bot_empty),
        .head_o  (bot_head)
    );

    // Net has priority until the bot has watched STARVE_LIMIT net grants go by.
    assign grant_bot = !bot_empty && (net_empty || (starve_q == STARVE_MAX));
    assign grant_net = !net_empty && !grant_bot;
    assign sel_entry = pop_bot ? bot_head : net_head;

    always_comb begin
        state_d       = state_q;
        pop_net       = 1'b0;
        pop_bot       = 1'b0;
        to_cnt_d      = '0;
        issued_d      = issued_q;
        err_no_ack_d  = err_no_ack_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !eng_busy && (grant_net || grant_bot)) begin
                    pop_net = grant_net;
                    pop_bot = grant_bot;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (eng_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    err_no_ack_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!eng_busy) begin
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
                    if (to_cnt_d >= TO_LIMIT) err_timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (bot_empty || pop_bot) begin
            starve_d = '0;
        end else if (pop_net && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Both sources can drop a zero-qty order in the same cycle.
    assign drop_sum = {1'b0, drop_q} + 17'(net_drop) + 17'(bot_drop);
    assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            starve_q      <= '0;
            to_cnt_q      <= '0;
            issued_q      <= '0;
            drop_q        <= '0;
            err_no_ack_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            eng_is_buy_q  <= 1'b0;
            eng_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            to_cnt_q      <= to_cnt_d;
            issued_q      <= issued_d;
            drop_q        <= drop_d;
            err_no_ack_q  <= err_no_ack_d;
            err_timeout_q <= err_timeout_d;
            if (pop_net || pop_bot) begin
                eng_is_buy_q <= sel_entry[ENTRY_W-1];
                eng_data_q   <= sel_entry[ORDER_W-1:0];
            end
        end
    end

    assign eng_valid   = (state_q == S_ISSUE);
    assign eng_is_buy  = eng_is_buy_q;
    assign eng_data    = eng_data_q;
    assign issued_cnt  = issued_q;
    assign drop_cnt    = drop_q;
    assign err_no_ack  = err_no_ack_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_order_ingress_sched.sv
// Directed bench for order_ingress_sched: a scoreboard queue of expected engine
// transfers, a negedge monitor that pops on every eng_valid, and a model engine.
module tb_order_ingress_sched;
    import order_ingress_sched_pkg::*;

    // Ingress handshake: transfer when valid && ready at a rising edge; the bench
    // drives inputs 1ns after the edge and samples outputs at #1 or on negedge.

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        net_valid = 1'b0, net_is_buy = 1'b0;
    logic        bot_valid = 1'b0, bot_is_buy = 1'b0;
    logic [31:0] net_data = '0, bot_data = '0;
    logic        eng_busy = 1'b0;
    logic        net_ready, bot_ready, eng_valid, eng_is_buy;
    logic [31:0] eng_data;
    logic [15:0] issued_cnt, drop_cnt;
    logic        err_no_ack, err_timeout;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [32:0] exp_q[$];
    int          eng_mode = 0;   // 0: normal engine, 1: never raises busy
    int          eng_hold = 4;
    logic [32:0] net_e[6], bot_e[6];

    order_ingress_sched dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .net_valid(net_valid), .net_ready(net_ready), .net_is_buy(net_is_buy), .net_data(net_data),
        .bot_valid(bot_valid), .bot_ready(bot_ready), .bot_is_buy(bot_is_buy), .bot_data(bot_data),
        .eng_valid(eng_valid), .eng_is_buy(eng_is_buy), .eng_data(eng_data), .eng_busy(eng_busy),
        .issued_cnt(issued_cnt), .drop_cnt(drop_cnt),
        .err_no_ack(err_no_ack), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [32:0] mk(input logic b, input logic [15:0] price,
                                       input logic id, input logic [14:0] qty);
        return {b, price, id, qty};
    endfunction

    // model engine: busy rises at the edge ending the issue cycle
    initial forever begin
        @(negedge clk);
        if (rst_n && eng_valid && eng_mode == 0) begin
            @(posedge clk);
            #1 eng_busy = 1'b1;
            repeat (eng_hold) @(posedge clk);
            #1 eng_busy = 1'b0;
        end
    end

    // scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && eng_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_eng_valid: got 0x%0h expected no transfer",
                         {eng_is_buy, eng_data});
            end else begin
                check("eng_transfer", {eng_is_buy, eng_data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks: called at #1 after a rising edge, return likewise
    task automatic push(input logic src, input logic is_buy, input logic [31:0] data);
        int guard = 0;
        if (src == SRC_NET) begin
            net_valid = 1'b1; net_is_buy = is_buy; net_data = data;
            while (!net_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        end else begin
            bot_valid = 1'b1; bot_is_buy = is_buy; bot_data = data;
            while (!bot_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL push_ready_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk); #1;
        net_valid = 1'b0;
        bot_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (!(exp_q.size() == 0 && dbg_state == S_IDLE && !eng_busy) && n < max_cycles) begin
            @(posedge clk); #1; n++;
        end
        if (n >= max_cycles) begin
            n_checks++;
            $display("FAIL wait_idle_timeout: got %0d pending, state %0d expected drained",
                     exp_q.size(), dbg_state);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int max_cycles);
        int n = 0;
        while (dbg_state != st && n < max_cycles) begin @(posedge clk); #1; n++; end
        if (n >= max_cycles) begin
            n_checks++;
            $display("FAIL wait_state_timeout: got state %0d expected %0d", dbg_state, st);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_net_ready"}, net_ready, 1);
        check({tag, "_bot_ready"}, bot_ready, 1);
        check({tag, "_eng_valid"}, eng_valid, 0);
        check({tag, "_eng_is_buy"}, eng_is_buy, 0);
        check({tag, "_eng_data"}, eng_data, 0);
        check({tag, "_issued_cnt"}, issued_cnt, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_err_no_ack"}, err_no_ack, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1;

        // 1: single net order, ID forced to 0, three-cycle latency
        exp_q.push_back(33'h1_0064_000A);
        push(SRC_NET, 1'b1, 32'h0064_800A);
        check("t1_pop_cycle_no_valid", eng_valid, 0);
        @(posedge clk); #1;
        check("t1_valid_latency", eng_valid, 1);
        check("t1_eng_data", eng_data, 32'h0064_000A);
        wait_idle(50);
        check("t1_issued_cnt", issued_cnt, 1);

        // 2: zero-qty bot order is accepted and dropped
        push(SRC_BOT, 1'b0, 32'h0123_0000);
        check("t2_bot_ready", bot_ready, 1);
        check("t2_drop_cnt", drop_cnt, 1);
        repeat (6) @(posedge clk);
        #1;
        check("t2_issued_cnt", issued_cnt, 1);

        // 3: starvation limit, expected grant order N N N N B N N B B B B B
        enable = 1'b0;
        eng_hold = 4;
        for (int i = 0; i < 6; i++) begin
            net_e[i] = mk(i[0], 16'h0100 + 16'(i), 1'b0, 15'h0001 + 15'(i));
            bot_e[i] = mk(~i[0], 16'h0200 + 16'(i), 1'b1, 15'h0010 + 15'(i));
            push(SRC_NET, i[0], {16'h0100 + 16'(i), 1'b1, 15'h0001 + 15'(i)});
            push(SRC_BOT, ~i[0], {16'h0200 + 16'(i), 1'b0, 15'h0010 + 15'(i)});
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(net_e[i]);
        exp_q.push_back(bot_e[0]);
        exp_q.push_back(net_e[4]);
        exp_q.push_back(net_e[5]);
        for (int i = 1; i < 6; i++) exp_q.push_back(bot_e[i]);
        enable = 1'b1;
        wait_idle(400);
        check("t3_issued_cnt", issued_cnt, 13);

        // 4: fill the net FIFO with issue held off, then drain in order
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(SRC_NET, 1'b0, {16'h0300 + 16'(i), 1'b0, 15'h0020 + 15'(i)});
            exp_q.push_back(mk(1'b0, 16'h0300 + 16'(i), 1'b0, 15'h0020 + 15'(i)));
        end
        check("t4_net_ready_full", net_ready, 0);
        check("t4_bot_ready", bot_ready, 1);
        enable = 1'b1;
        wait_idle(400);
        check("t4_issued_cnt", issued_cnt, 21);
        check("t4_net_ready_after", net_ready, 1);

        // 5a: engine never acknowledges
        eng_mode = 1;
        exp_q.push_back(mk(1'b1, 16'h0400, 1'b0, 15'h0005));
        push(SRC_NET, 1'b1, 32'h0400_0005);
        wait_idle(50);
        check("t5a_err_no_ack", err_no_ack, 1);
        check("t5a_state_idle", dbg_state, S_IDLE);
        check("t5a_issued_cnt", issued_cnt, 22);
        eng_mode = 0;

        // 5b: engine busy for 300 cycles trips the 255-cycle timeout
        eng_hold = 300;
        exp_q.push_back(mk(1'b0, 16'h0500, 1'b1, 15'h0007));
        push(SRC_BOT, 1'b0, 32'h0500_0007);
        wait_state(S_WAIT_DONE, 20);
        repeat (254) @(posedge clk);
        #1;
        check("t5b_timeout_before", err_timeout, 0);
        @(posedge clk); #1;
        check("t5b_timeout_at_255", err_timeout, 1);
        check("t5b_still_waiting", dbg_state, S_WAIT_DONE);
        wait_idle(100);
        eng_hold = 4;
        exp_q.push_back(mk(1'b1, 16'h0600, 1'b0, 15'h0009));
        push(SRC_NET, 1'b1, 32'h0600_0009);
        wait_idle(50);
        check("t5b_issued_cnt", issued_cnt, 24);
        check("t5b_timeout_sticky", err_timeout, 1);

        // 6: reset during S_WAIT_DONE with three orders queued
        eng_hold = 30;
        exp_q.push_back(mk(1'b0, 16'h0700, 1'b0, 15'h0001));
        push(SRC_NET, 1'b0, 32'h0700_0001);
        wait_state(S_WAIT_DONE, 20);
        push(SRC_NET, 1'b0, 32'h0701_0002);
        push(SRC_NET, 1'b1, 32'h0702_0003);
        push(SRC_BOT, 1'b0, 32'h0703_0004);
        check("t6_in_flight", dbg_state, S_WAIT_DONE);
        rst_n = 1'b0;
        eng_busy = 1'b0;
        #1;
        check_reset_values("t6_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("t6_issued_after", issued_cnt, 0);
        check("t6_state_after", dbg_state, S_IDLE);
        check("t6_net_ready_after", net_ready, 1);

        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
